// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_uses_rs2_i;
  logic             ex_mem_read_i;
  logic [4:0]       ex_rd_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             stall_all_o;
  logic             mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_uses_rs2_i, ex_mem_read_i, ex_rd_i,
           branch_taken_i, mem_req_i, mem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           stall_all_o, mem_timeout_o, stall_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_uses_rs2_i, ex_mem_read_i, ex_rd_i,
           branch_taken_i, mem_req_i, mem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           stall_all_o, mem_timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch squash, memory
// wait freeze with watchdog, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MAX_MEM_WAIT = 15,
  parameter int CNT_W        = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  pipe_hazard_ctrl_if.slave hz
);
  // state      | meaning
  // RUN        | normal issue, all hazards checked
  // LOAD_STALL | bubble already inserted, load-use masked for one cycle
  // MEM_WAIT   | data access outstanding, whole pipeline frozen
  // HALT       | watchdog expired, frozen until reset
  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT   = 2'd2;
  localparam logic [1:0] HALT       = 2'd3;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_MEM_WAIT);

  logic [1:0]       state, state_nxt;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout;
  logic             load_use, mem_miss;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, stall_all;

  assign load_use = hz.ex_mem_read_i && (hz.ex_rd_i != 5'd0) &&
                    ((hz.ex_rd_i == hz.id_rs1_i) ||
                     (hz.id_uses_rs2_i && (hz.ex_rd_i == hz.id_rs2_i)));
  assign mem_miss = hz.mem_req_i && !hz.mem_ready_i;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_all   = 1'b0;
    state_nxt   = RUN;
    if (rst_i) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state)
        RUN, LOAD_STALL: begin
          if (mem_miss) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_all  = 1'b1;
            state_nxt  = MEM_WAIT;
          end else if (hz.branch_taken_i) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use && (state == RUN)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_nxt   = LOAD_STALL;
          end
        end
        MEM_WAIT: begin
          if (!hz.mem_ready_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_all  = 1'b1;
            state_nxt  = (wait_cnt == WAIT_MAX) ? HALT : MEM_WAIT;
          end
        end
        default: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          stall_all  = 1'b1;
          state_nxt  = HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == RUN || state == LOAD_STALL) && mem_miss)
        wait_cnt <= 8'd1;
      else if (state == MEM_WAIT && state_nxt == MEM_WAIT)
        wait_cnt <= wait_cnt + 8'd1;
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      // sticky until reset; HALT can only be left through rst_i anyway
      if (state_nxt == HALT)
        timeout <= 1'b1;
    end
  end

  assign hz.pc_write_o    = pc_write;
  assign hz.ifid_write_o  = ifid_write;
  assign hz.ifid_flush_o  = ifid_flush;
  assign hz.idex_bubble_o = idex_bubble;
  assign hz.stall_all_o   = stall_all;
  assign hz.mem_timeout_o = timeout;
  assign hz.stall_cnt_o   = stall_cnt;
endmodule
